// File: rtl/mode_sequencer.sv
// Top-level mode controller for the minute/second timer: owns the operating state, generates
// the countdown seconds tick and alarm blink, and selects which block drives the display.
module mode_sequencer #(
    parameter int unsigned TICK_DIV      = 50_000_000,
    parameter int unsigned BLINK_DIV     = 25_000_000,
    parameter int unsigned ALARM_TIMEOUT = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        toggle,
    input  logic        increase,
    input  logic        programmed,
    input  logic        count_zero,
    input  logic [15:0] prog_digits,
    input  logic [15:0] count_digits,
    output logic [2:0]  currentState,
    output logic        sec_tick,
    output logic [15:0] digitsOut,
    output logic        blank,
    output logic        alarm
);

    localparam int unsigned TickW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned AlarmW = (ALARM_TIMEOUT > 1) ? $clog2(ALARM_TIMEOUT) : 1;

    localparam logic [TickW-1:0]  TickMax  = TickW'(TICK_DIV - 1);
    localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_DIV - 1);
    localparam logic [AlarmW-1:0] AlarmMax = AlarmW'(ALARM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StProg   = 3'd1,
        StCount  = 3'd2,
        StPaused = 3'd3,
        StAlarm  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [TickW-1:0]    presc_q, presc_d, presc_inc;
    logic [BlinkW-1:0]   blink_cnt_q, blink_cnt_d;
    logic                blink_q, blink_d;
    logic [AlarmW-1:0]   alarm_sec_q, alarm_sec_d;
    logic                programmed_q;
    logic                prog_rise;
    logic                presc_wrap;
    logic                leave_run;

    assign prog_rise  = programmed & ~programmed_q;
    assign presc_wrap = (presc_q == TickMax);
    assign presc_inc  = presc_wrap ? '0 : presc_q + 1'b1;
    // Leaving COUNTDOWN by a button (count_zero outranks toggle) must not emit a tick.
    assign leave_run  = start | (toggle & ~count_zero);
    assign sec_tick   = presc_wrap & (((state_q == StCount) & ~leave_run) | (state_q == StAlarm));

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = StProg;
            end
            StProg: begin
                if (start)          state_d = StIdle;
                else if (prog_rise) state_d = (prog_digits == 16'h0000) ? StIdle : StCount;
            end
            StCount: begin
                if (start)           state_d = StIdle;
                else if (count_zero) state_d = StAlarm;
                else if (toggle)     state_d = StPaused;
            end
            StPaused: begin
                if (start)       state_d = StIdle;
                else if (toggle) state_d = StCount;
            end
            StAlarm: begin
                if (start | toggle | increase)                 state_d = StIdle;
                else if (sec_tick && (alarm_sec_q == AlarmMax)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Counters are steered by the state being entered so entry clears and pauses hold cleanly.
    always_comb begin
        presc_d     = '0;
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        alarm_sec_d = '0;
        case (state_d)
            StCount: begin
                if (state_q == StCount)       presc_d = presc_inc;
                else if (state_q == StPaused) presc_d = presc_q;
            end
            StPaused: presc_d = presc_q;
            StAlarm: begin
                if (state_q == StAlarm) begin
                    presc_d     = presc_inc;
                    blink_cnt_d = (blink_cnt_q == BlinkMax) ? '0 : blink_cnt_q + 1'b1;
                    blink_d     = blink_q ^ (blink_cnt_q == BlinkMax);
                    alarm_sec_d = (sec_tick && (alarm_sec_q != AlarmMax)) ?
                                  alarm_sec_q + 1'b1 : alarm_sec_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            presc_q      <= '0;
            blink_cnt_q  <= '0;
            blink_q      <= 1'b0;
            alarm_sec_q  <= '0;
            programmed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
            alarm_sec_q  <= alarm_sec_d;
            programmed_q <= programmed;
        end
    end

    always_comb begin
        currentState = state_q;
        alarm        = (state_q == StAlarm);
        blank        = (state_q == StAlarm) & blink_q;
        case (state_q)
            StProg:            digitsOut = prog_digits;
            StCount, StPaused: digitsOut = count_digits;
            default:           digitsOut = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_mode_sequencer.sv
// Bench for mode_sequencer: directed vector table, hand-written corner sequences and random
// stimulus, all checked against a cycle-count based reference model.
module tb_mode_sequencer;

    localparam int TD = 4;
    localparam int BD = 2;
    localparam int AT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, toggle, increase, programmed, count_zero;
    logic [15:0] prog_digits, count_digits;
    logic [2:0]  currentState;
    logic        sec_tick;
    logic [15:0] digitsOut;
    logic        blank;
    logic        alarm;

    always #5 clk = ~clk;

    mode_sequencer #(
        .TICK_DIV      (TD),
        .BLINK_DIV     (BD),
        .ALARM_TIMEOUT (AT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .toggle       (toggle),
        .increase     (increase),
        .programmed   (programmed),
        .count_zero   (count_zero),
        .prog_digits  (prog_digits),
        .count_digits (count_digits),
        .currentState (currentState),
        .sec_tick     (sec_tick),
        .digitsOut    (digitsOut),
        .blank        (blank),
        .alarm        (alarm)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: mode 0..4, cycles spent running since countdown entry (pauses excluded),
    // cycles spent in alarm since entry, and last sampled programmed level.
    int m_mode;
    int m_run;
    int m_acyc;
    bit m_pprev;

    logic [2:0]  s_state;
    logic        s_tick, s_blank, s_alarm;
    logic [15:0] s_dig;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic bit m_tick();
        bit leave;
        leave = start || (!count_zero && toggle);
        if (m_mode == 2) return ((m_run % TD) == TD - 1) && !leave;
        if (m_mode == 4) return (m_acyc % TD) == TD - 1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] m_digits();
        if (m_mode == 1) return prog_digits;
        if (m_mode == 2 || m_mode == 3) return count_digits;
        return 16'h0000;
    endfunction

    function automatic bit m_blank();
        if (m_mode == 4) return ((m_acyc / BD) % 2) == 1;
        return 1'b0;
    endfunction

    task automatic m_reset();
        m_mode  = 0;
        m_run   = 0;
        m_acyc  = 0;
        m_pprev = 1'b0;
    endtask

    task automatic m_step();
        bit rise;
        bit tk;
        rise    = programmed && !m_pprev;
        tk      = m_tick();
        m_pprev = programmed;
        case (m_mode)
            0: if (start) m_mode = 1;
            1: begin
                if (start) m_mode = 0;
                else if (rise) begin
                    if (prog_digits == 16'h0000) m_mode = 0;
                    else begin
                        m_mode = 2;
                        m_run  = 0;
                    end
                end
            end
            2: begin
                if (start) m_mode = 0;
                else if (count_zero) begin
                    m_mode = 4;
                    m_acyc = 0;
                end else if (toggle) m_mode = 3;
                else m_run++;
            end
            3: begin
                if (start) m_mode = 0;
                else if (toggle) m_mode = 2;
            end
            4: begin
                if (start || toggle || increase) m_mode = 0;
                else if (tk && m_acyc == AT * TD - 1) m_mode = 0;
                else m_acyc++;
            end
            default: m_mode = 0;
        endcase
    endtask

    // One clock: drive inputs after negedge, sample/compare 1 time unit later, update model.
    task automatic do_cycle(input bit s, input bit t, input bit i, input bit p, input bit cz,
                            input logic [15:0] pd, input logic [15:0] cd);
        start        = s;
        toggle       = t;
        increase     = i;
        programmed   = p;
        count_zero   = cz;
        prog_digits  = pd;
        count_digits = cd;
        #1;
        s_state = currentState;
        s_tick  = sec_tick;
        s_dig   = digitsOut;
        s_blank = blank;
        s_alarm = alarm;
        chk("state",     16'(currentState), 16'(m_mode));
        chk("sec_tick",  16'(sec_tick),     16'(m_tick()));
        chk("digitsOut", digitsOut,         m_digits());
        chk("blank",     16'(blank),        16'(m_blank()));
        chk("alarm",     16'(alarm),        16'(m_mode == 4));
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    task automatic nop(input int n);
        for (int k = 0; k < n; k++) do_cycle(0, 0, 0, 0, 0, 16'h0005, 16'h0042);
    endtask

    // From IDLE: start, then a programmed rise with nonzero digits; next cycle is COUNTDOWN.
    task automatic go_countdown();
        do_cycle(0, 0, 0, 0, 0, 16'h0005, 16'h0042);
        do_cycle(1, 0, 0, 0, 0, 16'h0005, 16'h0042);
        do_cycle(0, 0, 0, 1, 0, 16'h0005, 16'h0042);
    endtask

    typedef struct {
        bit          s, t, i, p, cz;
        logic [15:0] pd, cd;
        logic [2:0]  st;
        bit          tk;
        logic [15:0] dig;
        bit          bl, al;
    } vec_t;

    vec_t tv[19];
    bit   blank_pat[12];

    initial begin
        //           s t i p cz  pd        cd        st    tk  dig       bl al
        tv[0]  = '{0,0,0,0,0, 16'h0005, 16'h1234, 3'd0, 0, 16'h0000, 0, 0};
        tv[1]  = '{0,0,1,0,0, 16'h0005, 16'h1234, 3'd0, 0, 16'h0000, 0, 0};
        tv[2]  = '{1,0,0,0,0, 16'h0005, 16'h1234, 3'd0, 0, 16'h0000, 0, 0};
        tv[3]  = '{0,0,0,0,0, 16'h0005, 16'h1234, 3'd1, 0, 16'h0005, 0, 0};
        tv[4]  = '{0,0,0,1,0, 16'h0005, 16'h1234, 3'd1, 0, 16'h0005, 0, 0};
        tv[5]  = '{0,0,0,1,0, 16'h0005, 16'h0059, 3'd2, 0, 16'h0059, 0, 0};
        tv[6]  = '{0,0,0,1,0, 16'h0005, 16'h0058, 3'd2, 0, 16'h0058, 0, 0};
        tv[7]  = '{0,0,0,1,0, 16'h0005, 16'h0042, 3'd2, 0, 16'h0042, 0, 0};
        tv[8]  = '{0,0,0,1,0, 16'h0005, 16'h0042, 3'd2, 1, 16'h0042, 0, 0};
        tv[9]  = '{0,0,1,1,0, 16'h0005, 16'h0042, 3'd2, 0, 16'h0042, 0, 0};
        tv[10] = '{0,1,0,1,0, 16'h0005, 16'h0042, 3'd2, 0, 16'h0042, 0, 0};
        tv[11] = '{0,0,0,1,0, 16'h0005, 16'h0042, 3'd3, 0, 16'h0042, 0, 0};
        tv[12] = '{0,1,0,1,0, 16'h0005, 16'h0042, 3'd3, 0, 16'h0042, 0, 0};
        tv[13] = '{0,0,0,1,0, 16'h0005, 16'h0042, 3'd2, 0, 16'h0042, 0, 0};
        tv[14] = '{0,0,0,1,0, 16'h0005, 16'h0042, 3'd2, 0, 16'h0042, 0, 0};
        tv[15] = '{0,0,0,1,1, 16'h0005, 16'h0042, 3'd2, 1, 16'h0042, 0, 0};
        tv[16] = '{0,0,0,1,0, 16'h0005, 16'h0042, 3'd4, 0, 16'h0000, 0, 1};
        tv[17] = '{0,0,1,1,0, 16'h0005, 16'h0042, 3'd4, 0, 16'h0000, 0, 1};
        tv[18] = '{0,0,0,0,0, 16'h0005, 16'h0042, 3'd0, 0, 16'h0000, 0, 0};
        blank_pat = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1};

        rst_n = 1'b0;
        start = 0; toggle = 0; increase = 0; programmed = 0; count_zero = 0;
        prog_digits = 16'h0000; count_digits = 16'h0000;
        m_reset();
        @(negedge clk);
        chk("reset_state",  16'(currentState), 16'h0000);
        chk("reset_tick",   16'(sec_tick),     16'h0000);
        chk("reset_digits", digitsOut,         16'h0000);
        chk("reset_blank",  16'(blank),        16'h0000);
        chk("reset_alarm",  16'(alarm),        16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 19; k++) begin
            do_cycle(tv[k].s, tv[k].t, tv[k].i, tv[k].p, tv[k].cz, tv[k].pd, tv[k].cd);
            chk($sformatf("vec%0d_state", k),  16'(s_state), 16'(tv[k].st));
            chk($sformatf("vec%0d_tick", k),   16'(s_tick),  16'(tv[k].tk));
            chk($sformatf("vec%0d_digits", k), s_dig,        tv[k].dig);
            chk($sformatf("vec%0d_blank", k),  16'(s_blank), 16'(tv[k].bl));
            chk($sformatf("vec%0d_alarm", k),  16'(s_alarm), 16'(tv[k].al));
        end

        // Zero programmed digits abort to IDLE; a held programmed level does not re-trigger.
        do_cycle(1, 0, 0, 0, 0, 16'h0000, 16'h0042);
        do_cycle(0, 0, 0, 1, 0, 16'h0000, 16'h0042);
        for (int k = 0; k < 20; k++) begin
            do_cycle(0, 0, 0, 1, 0, 16'h0005, 16'h0042);
            chk("zero_prog_stays_idle", 16'(s_state), 16'h0000);
        end

        // Pause with prescaler at 2; resume ticks two cycles after the toggle.
        go_countdown();
        nop(2);
        do_cycle(0, 1, 0, 0, 0, 16'h0005, 16'h0042);
        for (int k = 0; k < 10; k++) begin
            nop(1);
            chk("paused_state",   16'(s_state), 16'h0003);
            chk("paused_no_tick", 16'(s_tick),  16'h0000);
        end
        do_cycle(0, 1, 0, 0, 0, 16'h0005, 16'h0042);
        nop(1);
        chk("resume_tick_early", 16'(s_tick), 16'h0000);
        nop(1);
        chk("resume_tick_due", 16'(s_tick), 16'h0001);

        // count_zero beats toggle; alarm blinks then times out after 3 ticks.
        do_cycle(0, 1, 0, 0, 1, 16'h0005, 16'h0042);
        for (int k = 0; k < 12; k++) begin
            nop(1);
            chk($sformatf("alarm_blank%0d", k), 16'(s_blank), 16'(blank_pat[k]));
            chk("alarm_on", 16'(s_alarm), 16'h0001);
        end
        nop(1);
        chk("timeout_state", 16'(s_state), 16'h0000);
        chk("timeout_alarm", 16'(s_alarm), 16'h0000);

        // start outranks count_zero in COUNTDOWN.
        go_countdown();
        nop(1);
        do_cycle(1, 0, 0, 0, 1, 16'h0005, 16'h0042);
        nop(1);
        chk("start_beats_zero", 16'(s_state), 16'h0000);

        // increase during ALARM (while blank is high) returns to IDLE with display lit.
        go_countdown();
        do_cycle(0, 0, 0, 0, 1, 16'h0005, 16'h0042);
        nop(3);
        chk("alarm_blank_high", 16'(s_blank), 16'h0001);
        do_cycle(0, 0, 1, 0, 0, 16'h0005, 16'h0042);
        nop(1);
        chk("inc_exit_state", 16'(s_state), 16'h0000);
        chk("inc_exit_alarm", 16'(s_alarm), 16'h0000);
        chk("inc_exit_blank", 16'(s_blank), 16'h0000);

        // Asynchronous reset in COUNTDOWN with the prescaler about to tick.
        go_countdown();
        nop(3);
        rst_n = 1'b0;
        #1;
        chk("async_rst_state",  16'(currentState), 16'h0000);
        chk("async_rst_tick",   16'(sec_tick),     16'h0000);
        chk("async_rst_digits", digitsOut,         16'h0000);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        begin
            bit p_lvl;
            p_lvl = 1'b0;
            for (int k = 0; k < 3000; k++) begin
                logic [15:0] pd;
                if ($urandom_range(3) == 0) p_lvl = ~p_lvl;
                pd = ($urandom_range(3) == 0) ? 16'h0000 : 16'($urandom);
                do_cycle($urandom_range(11) == 0, $urandom_range(7) == 0,
                         $urandom_range(7) == 0, p_lvl, $urandom_range(9) == 0,
                         pd, 16'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
